// File: rtl/frame_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// frame_scheduler_pkg
//
// Project-wide globals for the frame pipeline: default frame size, default
// watchdog limit and the scheduler state encoding shared by the scheduler
// RTL and anything that decodes its state_o port.
// ---------------------------------------------------------------------------
package frame_scheduler_pkg;

    // Pixels per frame, identical for the image and the mask stream.
    localparam int IMAGE_SIZE      = 720 * 540;

    // Default number of stalled cycles before the scheduler gives up.
    localparam int WATCHDOG_CYCLES = 2 ** 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EDGE  = 3'd2,
        HOUGH = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } sched_state_t;

endpackage

// File: rtl/frame_scheduler.sv
// ---------------------------------------------------------------------------
// frame_scheduler
//
// Sequences one frame through the pipeline: accept IMAGE_SIZE image and mask
// pixels from the upstream FIFOs, wait for hysteresis to finish its BRAM,
// kick the hough accumulator and report completion.
//
// Optional feature: define FRAME_SCHEDULER_WATCHDOG_EN to build a stall
// watchdog that moves the scheduler to ERR after WATCHDOG_CYCLES cycles
// without progress. Without it, error is tied low and ERR is unreachable.
//
// Ports
//   clock        in   single clock
//   reset        in   asynchronous active-high reset
//   frame_go     in   one-cycle frame start request (honoured in IDLE only)
//   abort        in   abandon the current frame (ignored in IDLE)
//   image_wr_en  in   upstream image FIFO write strobe
//   image_full   in   upstream image FIFO full flag
//   mask_wr_en   in   upstream mask FIFO write strobe
//   mask_full    in   upstream mask FIFO full flag
//   edge_done    in   hysteresis finished writing its BRAM
//   hough_done   in   hough accumulator result valid
//   image_accept out  write gate for the image FIFO
//   mask_accept  out  write gate for the mask FIFO
//   hough_start  out  one-cycle start pulse to hough
//   frame_done   out  one-cycle end-of-frame pulse
//   busy         out  scheduler not in IDLE
//   state_o      out  current state encoding
//   frame_count  out  completed frames, wraps at 16 bits
//   error        out  watchdog fired
//
// All outputs are decoded from registers only; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module frame_scheduler #(
    parameter int IMAGE_SIZE      = frame_scheduler_pkg::IMAGE_SIZE,
    parameter int WATCHDOG_CYCLES = frame_scheduler_pkg::WATCHDOG_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_go,
    input  logic        abort,
    input  logic        image_wr_en,
    input  logic        image_full,
    input  logic        mask_wr_en,
    input  logic        mask_full,
    input  logic        edge_done,
    input  logic        hough_done,
    output logic        image_accept,
    output logic        mask_accept,
    output logic        hough_start,
    output logic        frame_done,
    output logic        busy,
    output logic [2:0]  state_o,
    output logic [15:0] frame_count,
    output logic        error
);
    import frame_scheduler_pkg::*;

    localparam int            CW       = $clog2(IMAGE_SIZE + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(IMAGE_SIZE);

    sched_state_t  state_q, state_d;
    logic [CW-1:0] img_cnt_q, img_cnt_d;
    logic [CW-1:0] msk_cnt_q, msk_cnt_d;
    logic          edge_latch_q, edge_latch_d;
    logic          hough_start_q, hough_start_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          img_beat, msk_beat;

`ifdef FRAME_SCHEDULER_WATCHDOG_EN
    localparam int            WW      = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_CYCLES - 1);
    logic [WW-1:0] stall_q, stall_d;
    logic          progress;
`endif

    // Accept gates come from registered state, so the beat that completes a
    // stream drops its gate on the following cycle.
    assign image_accept = (state_q == LOAD) && (img_cnt_q < FULL_CNT);
    assign mask_accept  = (state_q == LOAD) && (msk_cnt_q < FULL_CNT);
    assign img_beat     = image_wr_en & ~image_full & image_accept;
    assign msk_beat     = mask_wr_en  & ~mask_full  & mask_accept;

    assign hough_start  = hough_start_q;
    assign frame_done   = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign state_o      = state_q;
    assign frame_count  = frame_count_q;
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
    assign error        = (state_q == ERR);
`else
    assign error        = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        img_cnt_d     = img_cnt_q;
        msk_cnt_d     = msk_cnt_q;
        edge_latch_d  = edge_latch_q;
        hough_start_d = 1'b0;
        frame_count_d = frame_count_q;

        case (state_q)
            IDLE: begin
                // Counters and latch are held clear while idle, so a new
                // frame always starts from zero.
                img_cnt_d    = '0;
                msk_cnt_d    = '0;
                edge_latch_d = 1'b0;
                if (frame_go) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (img_beat) img_cnt_d = img_cnt_q + 1'b1;
                if (msk_beat) msk_cnt_d = msk_cnt_q + 1'b1;
                edge_latch_d = edge_latch_q | edge_done;
                if ((img_cnt_q == FULL_CNT) && (msk_cnt_q == FULL_CNT)) begin
                    state_d = EDGE;
                end
            end
            EDGE: begin
                edge_latch_d = edge_latch_q | edge_done;
                if (edge_latch_q) begin
                    state_d       = HOUGH;
                    hough_start_d = 1'b1;
                end
            end
            HOUGH: begin
                if (hough_done) begin
                    // Counting on DONE entry keeps frame_count consistent
                    // with the frame_done pulse shown during DONE.
                    state_d       = DONE;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef FRAME_SCHEDULER_WATCHDOG_EN
        stall_d  = '0;
        progress = img_beat | msk_beat | (state_d != state_q) |
                   (edge_done & ((state_q == LOAD) | (state_q == EDGE)));
        if ((state_q == LOAD) || (state_q == EDGE) || (state_q == HOUGH)) begin
            if (progress) begin
                stall_d = '0;
            end else if (stall_q == WD_LAST) begin
                state_d = ERR;
                stall_d = '0;
            end else begin
                stall_d = stall_q + 1'b1;
            end
        end
`endif

        // Abort overrides every other transition and discards the frame.
        if (abort && (state_q != IDLE)) begin
            state_d       = IDLE;
            img_cnt_d     = '0;
            msk_cnt_d     = '0;
            edge_latch_d  = 1'b0;
            hough_start_d = 1'b0;
            frame_count_d = frame_count_q;
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
            stall_d       = '0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            img_cnt_q     <= '0;
            msk_cnt_q     <= '0;
            edge_latch_q  <= 1'b0;
            hough_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            img_cnt_q     <= img_cnt_d;
            msk_cnt_q     <= msk_cnt_d;
            edge_latch_q  <= edge_latch_d;
            hough_start_q <= hough_start_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef FRAME_SCHEDULER_WATCHDOG_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_scheduler
//
// Directed bench for frame_scheduler with IMAGE_SIZE=16, WATCHDOG_CYCLES=100.
// A vector table covers single-cycle control behaviour; hand-written
// sequences cover full frames, accept gating, edge latching, abort, the
// watchdog (when FRAME_SCHEDULER_WATCHDOG_EN is defined) and async reset.
// ---------------------------------------------------------------------------
module tb_frame_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_go, abort;
    logic        image_wr_en, image_full, mask_wr_en, mask_full;
    logic        edge_done, hough_done;
    logic        image_accept, mask_accept, hough_start, frame_done, busy;
    logic [2:0]  state_o;
    logic [15:0] frame_count;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    frame_scheduler #(.IMAGE_SIZE(16), .WATCHDOG_CYCLES(100)) dut (
        .clock        (clock),
        .reset        (reset),
        .frame_go     (frame_go),
        .abort        (abort),
        .image_wr_en  (image_wr_en),
        .image_full   (image_full),
        .mask_wr_en   (mask_wr_en),
        .mask_full    (mask_full),
        .edge_done    (edge_done),
        .hough_done   (hough_done),
        .image_accept (image_accept),
        .mask_accept  (mask_accept),
        .hough_start  (hough_start),
        .frame_done   (frame_done),
        .busy         (busy),
        .state_o      (state_o),
        .frame_count  (frame_count),
        .error        (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       go, ab, iw, ifl, mw, mfl, ed, hd;
        logic [2:0] st;
        logic       ia, ma, hs, fd, bz;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic go, ab, iw, ifl, mw, mfl, ed, hd,
                                input logic [2:0] st, input logic ia, ma, hs, fd, bz,
                                input logic [15:0] fc);
        vec_t v;
        v.go = go; v.ab = ab; v.iw = iw; v.ifl = ifl;
        v.mw = mw; v.mfl = mfl; v.ed = ed; v.hd = hd;
        v.st = st; v.ia = ia; v.ma = ma; v.hs = hs; v.fd = fd; v.bz = bz; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic ia, ma, hs, fd, bz,
                             input logic [15:0] fc);
        chk({tag, ".state"},        32'(state_o),      32'(st));
        chk({tag, ".image_accept"}, 32'(image_accept), 32'(ia));
        chk({tag, ".mask_accept"},  32'(mask_accept),  32'(ma));
        chk({tag, ".hough_start"},  32'(hough_start),  32'(hs));
        chk({tag, ".frame_done"},   32'(frame_done),   32'(fd));
        chk({tag, ".busy"},         32'(busy),         32'(bz));
        chk({tag, ".frame_count"},  32'(frame_count),  32'(fc));
    endtask

    task automatic set_in(input logic go, ab, iw, ifl, mw, mfl, ed, hd);
        frame_go = go; abort = ab; image_wr_en = iw; image_full = ifl;
        mask_wr_en = mw; mask_full = mfl; edge_done = ed; hough_done = hd;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Start a frame and deliver 16 image and 16 mask beats together; leaves
    // the scheduler in EDGE. Optionally pulses edge_done during the load.
    task automatic run_load(input logic with_edge, input string tag);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk({tag, ".load_entry"}, 32'(state_o), 32'd1);
        for (int i = 0; i < 16; i++) begin
            set_in(0, 0, 1, 0, 1, 0, with_edge && (i == 4), 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk({tag, ".edge_entry"}, 32'(state_o), 32'd2);
        $display("%s: load complete, state=%0d", tag, state_o);
    endtask

    initial begin
        int exp_img;

        // ---------------- reset ----------------
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        check_all("reset", 3'd0, 0, 0, 0, 0, 0, 16'd0);
        chk("reset.error", 32'(error), 32'd0);
        reset = 1'b0;
        tick();

        // ---------------- vector table ----------------
        //           go ab iw if mw mf ed hd  st  ia ma hs fd bz fc
        vecs[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 16'd0);
        vecs[1] = mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 16'd0); // abort ignored in IDLE
        vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 0, 0, 16'd0); // hough_done ignored in IDLE
        vecs[3] = mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd1, 1, 1, 0, 0, 1, 16'd0); // go -> LOAD
        vecs[4] = mk(1, 0, 1, 1, 0, 0, 0, 0, 3'd1, 1, 1, 0, 0, 1, 16'd0); // go ignored, full blocks
        vecs[5] = mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd1, 1, 1, 0, 0, 1, 16'd0); // edge_done in LOAD
        vecs[6] = mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 16'd0); // abort in LOAD
        vecs[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 16'd0);
        vecs[8] = mk(1, 1, 0, 0, 0, 0, 0, 0, 3'd1, 1, 1, 0, 0, 1, 16'd0); // go+abort in IDLE -> LOAD
        vecs[9] = mk(0, 0, 1, 0, 0, 0, 0, 1, 3'd1, 1, 1, 0, 0, 1, 16'd0); // hough_done ignored in LOAD

        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].go, vecs[i].ab, vecs[i].iw, vecs[i].ifl,
                   vecs[i].mw, vecs[i].mfl, vecs[i].ed, vecs[i].hd);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ia, vecs[i].ma,
                      vecs[i].hs, vecs[i].fd, vecs[i].bz, vecs[i].fc);
            $display("vec %0d: state=%0d ia=%0b ma=%0b busy=%0b", i, state_o,
                     image_accept, mask_accept, busy);
        end
        chk("vec9.img_cnt", 32'(dut.img_cnt_q), 32'd1);
        set_in(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post_table.abort", 32'(state_o), 32'd0);
        chk("post_table.img_cnt", 32'(dut.img_cnt_q), 32'd0);

        // ---------------- full frame with accept gating ----------------
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("frame1.load", 32'(state_o), 32'd1);
        exp_img = 0;
        for (int i = 0; i < 20; i++) begin
            set_in(0, 0, 1, (i == 2) || (i == 7), 0, 0, 0, 0);
            chk($sformatf("frame1.img_accept%0d", i), 32'(image_accept), 32'(exp_img < 16));
            if (!image_full && exp_img < 16) exp_img++;
            tick();
        end
        chk("frame1.img_cnt", 32'(dut.img_cnt_q), 32'd16);
        chk("frame1.img_accept_low", 32'(image_accept), 32'd0);
        chk("frame1.still_load", 32'(state_o), 32'd1);
        $display("frame1: image stream done, count=%0d", dut.img_cnt_q);
        for (int i = 0; i < 16; i++) begin
            set_in(0, 0, 1, 0, 1, 0, (i == 8), 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("frame1.msk_cnt", 32'(dut.msk_cnt_q), 32'd16);
        chk("frame1.img_cnt_hold", 32'(dut.img_cnt_q), 32'd16);
        check_all("frame1.loaded", 3'd1, 0, 0, 0, 0, 1, 16'd0);
        tick();
        check_all("frame1.edge", 3'd2, 0, 0, 0, 0, 1, 16'd0);
        tick();
        check_all("frame1.hough", 3'd3, 0, 0, 1, 0, 1, 16'd0);
        tick();
        check_all("frame1.hough2", 3'd3, 0, 0, 0, 0, 1, 16'd0);
        repeat (9) tick();
        chk("frame1.hough_wait", 32'(state_o), 32'd3);
        chk("frame1.no_early_done", 32'(frame_done), 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        check_all("frame1.done", 3'd4, 0, 0, 0, 1, 1, 16'd1);
        tick();
        check_all("frame1.idle", 3'd0, 0, 0, 0, 0, 0, 16'd1);
        $display("frame1: complete, frame_count=%0d", frame_count);

        // ---------------- edge latching in EDGE, abort in HOUGH ----------------
        run_load(0, "frame2");
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("frame2.hd_ignored", 32'(state_o), 32'd2);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        chk("frame2.edge_wait", 32'(state_o), 32'd2);
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        chk("frame2.latch_cycle", 32'(state_o), 32'd2);
        tick();
        check_all("frame2.hough", 3'd3, 0, 0, 1, 0, 1, 16'd1);
        set_in(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        check_all("frame2.abort", 3'd0, 0, 0, 0, 0, 0, 16'd1);
        tick();
        check_all("frame2.after_abort", 3'd0, 0, 0, 0, 0, 0, 16'd1);
        $display("frame2: aborted in HOUGH, frame_count=%0d", frame_count);

        run_load(1, "frame3");
        tick();
        check_all("frame3.hough", 3'd3, 0, 0, 1, 0, 1, 16'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        check_all("frame3.done", 3'd4, 0, 0, 0, 1, 1, 16'd2);
        tick();
        check_all("frame3.idle", 3'd0, 0, 0, 0, 0, 0, 16'd2);
        $display("frame3: complete, frame_count=%0d", frame_count);

        // ---------------- watchdog ----------------
        run_load(1, "frame4");
        tick();
        chk("frame4.hough", 32'(state_o), 32'd3);
        repeat (99) tick();
        chk("frame4.hough99", 32'(state_o), 32'd3);
        chk("frame4.error99", 32'(error), 32'd0);
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
        tick();
        check_all("frame4.err", 3'd5, 0, 0, 0, 0, 1, 16'd2);
        chk("frame4.error", 32'(error), 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("frame4.err_sticky", 32'(state_o), 32'd5);
        chk("frame4.err_no_done", 32'(frame_done), 32'd0);
`else
        repeat (30) tick();
        chk("frame4.no_watchdog", 32'(state_o), 32'd3);
        chk("frame4.error_tied", 32'(error), 32'd0);
`endif
        set_in(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        check_all("frame4.abort", 3'd0, 0, 0, 0, 0, 0, 16'd2);
        chk("frame4.error_clear", 32'(error), 32'd0);
        $display("frame4: stall handled, state=%0d error=%0b", state_o, error);

        // ---------------- async reset mid-LOAD ----------------
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 1, i[0], 1, 0, 0, 0);
            tick();
        end
        chk("rst.pre_img_cnt", 32'(dut.img_cnt_q), 32'd3);
        #3;
        reset = 1'b1;
        #1;
        check_all("rst.async", 3'd0, 0, 0, 0, 0, 0, 16'd0);
        chk("rst.async_error", 32'(error), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rst.img_cnt", 32'(dut.img_cnt_q), 32'd0);
        chk("rst.msk_cnt", 32'(dut.msk_cnt_q), 32'd0);
        check_all("rst.after", 3'd0, 0, 0, 0, 0, 0, 16'd0);
        $display("reset: mid-LOAD reset cleared state=%0d", state_o);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
